divide: RTL

DIVIDE -- requirements
Module: divide

---
 rtl/divide.sv | 115 +++++++++++
 1 files changed

// File: rtl/divide.sv
// Sign-magnitude restoring divider, one quotient bit per clock, WIDTH-cycle latency.
// Define DIVIDE_ZERO_DETECT_EN to short-circuit a zero divisor with a 1-cycle result.
module divide #(
    parameter int WIDTH = 8
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             ready,
    output logic             sign,
    output logic [WIDTH-2:0] quotient,
    output logic [WIDTH-2:0] remainder,
    output logic             div_by_zero
);
    localparam int M  = WIDTH - 1;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [M-1:0]   dvd;      // dividend bits shift out, quotient bits shift in
    logic [M-1:0]   dvs;
    logic [M:0]     rem;      // one guard bit above the magnitude
    logic           sign_q;
    logic           accept;
    logic [M+1:0]   shifted;
    logic           ge;
    logic [M:0]     rem_nxt;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: if (start) begin
                accept    = 1'b1;
                state_nxt = CALC;
            end
            CALC:    if (cnt == '0) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shifted = {rem, dvd[M-1]};
        ge      = shifted >= (M+2)'(dvs);
        rem_nxt = ge ? WIDTH'(shifted - (M+2)'(dvs)) : shifted[M:0];
    end

`ifdef DIVIDE_ZERO_DETECT_EN
    logic zero;
    logic zero_in;
    assign zero_in = (divisor_in[M-1:0] == '0);
`endif

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            sign_q    <= 1'b0;
            ready     <= 1'b0;
            sign      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIVIDE_ZERO_DETECT_EN
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
`endif
        end else if (accept) begin
            dvd    <= dividend_in[M-1:0];
            dvs    <= divisor_in[M-1:0];
            rem    <= '0;
            sign_q <= dividend_in[M] ^ divisor_in[M];
            ready  <= 1'b0;
`ifdef DIVIDE_ZERO_DETECT_EN
            zero   <= zero_in;
            // A zero divisor skips the iterations: counter 0 means result next edge
            cnt    <= zero_in ? '0 : CW'(M);
`else
            cnt    <= CW'(M);
`endif
        end else if (state == CALC) begin
            if (cnt != '0) begin
                dvd <= {dvd[M-2:0], ge};
                rem <= rem_nxt;
                cnt <= cnt - 1'b1;
            end else begin
                ready <= 1'b1;
                sign  <= sign_q;
`ifdef DIVIDE_ZERO_DETECT_EN
                quotient    <= zero ? '1  : dvd;
                remainder   <= zero ? dvd : rem[M-1:0];
                div_by_zero <= zero;
`else
                quotient    <= dvd;
                remainder   <= rem[M-1:0];
`endif
            end
        end
    end

`ifndef DIVIDE_ZERO_DETECT_EN
    assign div_by_zero = 1'b0;
`endif

endmodule
